// File: rtl/fifos_8x8_drain.sv
// Read-side merger: drains eight show-ahead FIFOs into one tagged valid/ready stream.
// Optional macro DRAIN_RR_EN selects round-robin arbitration (default: fixed priority).
module fifos_8x8_drain #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 i_data_vld,
    input  logic [7:0][DATA_WIDTH-1:0] i_data,
    output logic [7:0]                 o_rden,
    output logic                       o_vld,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [2:0]                 o_src,
    input  logic                       i_rdy
);

    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [2:0]            buf_src_q [2];
    logic [2:0]            buf_src_d [2];

    logic       pop_ok;
    logic       any_vld;
    logic [2:0] gnt_idx;
    logic       push;
    logic       pop;

`ifdef DRAIN_RR_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;

    // Walk offsets high-to-low so the closest valid source after ptr wins.
    always_comb begin
        any_vld = 1'b0;
        gnt_idx = rr_ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (i_data_vld[rr_ptr_q + 3'(i)]) begin
                any_vld = 1'b1;
                gnt_idx = rr_ptr_q + 3'(i);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = gnt_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= 3'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        any_vld = 1'b0;
        gnt_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (i_data_vld[i]) begin
                any_vld = 1'b1;
                gnt_idx = 3'(i);
            end
        end
    end
`endif

    // Only registered occupancy gates the pop, keeping i_rdy off the o_rden path.
    assign pop_ok = (count_q != 2'd2) & rst;
    assign o_rden = (pop_ok & any_vld) ? (8'd1 << gnt_idx) : 8'd0;
    assign push   = |o_rden;

    assign o_vld  = (count_q != 2'd0) & rst;
    assign o_data = rst ? buf_data_q[rd_ptr_q] : '0;
    assign o_src  = rst ? buf_src_q[rd_ptr_q] : 3'd0;
    assign pop    = o_vld & i_rdy;

    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_data_d = buf_data_q;
        buf_src_d  = buf_src_q;
        if (push) begin
            buf_data_d[wr_ptr_q] = i_data[gnt_idx];
            buf_src_d[wr_ptr_q]  = gnt_idx;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_src_q[0]  <= 3'd0;
            buf_src_q[1]  <= 3'd0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            buf_data_q <= buf_data_d;
            buf_src_q  <= buf_src_d;
        end
    end

endmodule
